id_stage: RTL and testbench

- Instruction-decode stage of the 5-stage pipeline, placed between the IF/ID register and EX.
- Contains the register file, the opcode decode and operand selection, and branch resolution.
- Ends in the registered ID/EX boundary that feeds EX.
- Opcode decode is done by an internal instance of control_unit.

---
 rtl/id_stage.sv | 174 +++++++++++++++++
 tb/tb_id_stage.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
// Instruction-decode stage: register file with same-cycle WB bypass, decode, operand select, branch resolve.
// Latency: branch decision and read addresses are combinational; the ID/EX outputs are valid one cycle later.
// Backpressure: hazard_stall or flush loads a bubble into ID/EX, and hazard_stall also suppresses br_taken.

// Opcode decode: an unknown opcode or NOP gives all-zero controls.
module control_unit (
  input  logic [5:0] opcode,
  output logic [3:0] exe_cmd,
  output logic       mem_read,
  output logic       mem_write,
  output logic       wb_en,
  output logic       is_immediate,
  output logic [1:0] br_type
);

  // Map each opcode to its EX command and its MEM/WB controls.
  always_comb begin
    exe_cmd      = 4'd0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    wb_en        = 1'b0;
    is_immediate = 1'b0;
    br_type      = 2'd0;
    case (opcode)
      6'd1:  begin exe_cmd = 4'd0;  wb_en = 1'b1; end                        // ADD
      6'd3:  begin exe_cmd = 4'd2;  wb_en = 1'b1; end                        // SUB
      6'd5:  begin exe_cmd = 4'd4;  wb_en = 1'b1; end                        // AND
      6'd6:  begin exe_cmd = 4'd5;  wb_en = 1'b1; end                        // OR
      6'd7:  begin exe_cmd = 4'd6;  wb_en = 1'b1; end                        // NOR
      6'd8:  begin exe_cmd = 4'd7;  wb_en = 1'b1; end                        // XOR
      6'd9:  begin exe_cmd = 4'd8;  wb_en = 1'b1; end                        // SLA
      6'd10: begin exe_cmd = 4'd8;  wb_en = 1'b1; end                        // SLL
      6'd11: begin exe_cmd = 4'd9;  wb_en = 1'b1; end                        // SRA
      6'd12: begin exe_cmd = 4'd10; wb_en = 1'b1; end                        // SRL
      6'd32: begin exe_cmd = 4'd0;  wb_en = 1'b1; is_immediate = 1'b1; end   // ADDI
      6'd33: begin exe_cmd = 4'd2;  wb_en = 1'b1; is_immediate = 1'b1; end   // SUBI
      6'd36: begin mem_read = 1'b1; wb_en = 1'b1; is_immediate = 1'b1; end   // LD
      6'd37: begin mem_write = 1'b1; is_immediate = 1'b1; end                // ST
      6'd40: begin is_immediate = 1'b1; br_type = 2'd1; end                  // BEZ
      6'd41: begin is_immediate = 1'b1; br_type = 2'd2; end                  // BNE
      6'd42: begin is_immediate = 1'b1; br_type = 2'd3; end                  // JMP
      default: ;
    endcase
  end

endmodule

module id_stage #(
  parameter int DATA_W = 32,
  parameter int REG_N  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       instruction,
  input  logic [31:0]       pc_in,
  input  logic              hazard_stall,
  input  logic              flush,
  input  logic              wb_en_in,
  input  logic [4:0]        wb_dest,
  input  logic [DATA_W-1:0] wb_value,
  output logic [4:0]        src1,
  output logic [4:0]        src2,
  output logic              two_src,
  output logic              br_taken,
  output logic [31:0]       br_addr,
  output logic [31:0]       ex_pc,
  output logic [DATA_W-1:0] ex_val1,
  output logic [DATA_W-1:0] ex_val2,
  output logic [DATA_W-1:0] ex_st_val,
  output logic [4:0]        ex_dest,
  output logic [4:0]        ex_src1,
  output logic [4:0]        ex_src2,
  output logic [3:0]        ex_exe_cmd,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_wb_en
);

  logic [DATA_W-1:0] rf [REG_N];

  logic [3:0]        exe_cmd;
  logic              mem_read, mem_write, wb_en, is_immediate;
  logic [1:0]        br_type;
  logic [4:0]        dest_f, src2_f;
  logic              is_bne;
  logic [DATA_W-1:0] port1, port2, simm;

  control_unit u_ctrl (
    .opcode       (instruction[31:26]),
    .exe_cmd      (exe_cmd),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .wb_en        (wb_en),
    .is_immediate (is_immediate),
    .br_type      (br_type)
  );

  assign dest_f = instruction[25:21];
  assign src1   = instruction[20:16];
  assign src2_f = instruction[15:11];
  assign is_bne = (br_type == 2'd2);
  // Stores and BNE compare or store the register named in the dest field.
  assign src2   = (mem_write | is_bne) ? dest_f : src2_f;
  assign two_src = ~is_immediate | mem_write | is_bne;
  assign simm   = {{(DATA_W-16){instruction[15]}}, instruction[15:0]};

  // A read of R0 gives 0; a read of the register being written back this cycle gives the WB value.
  function automatic logic [DATA_W-1:0] rd_port(input logic [4:0] a);
    if (a == 5'd0)
      return '0;
    else if (wb_en_in && (wb_dest == a))
      return wb_value;
    else
      return rf[a];
  endfunction

  assign port1 = rd_port(src1);
  assign port2 = rd_port(src2);

  // Resolve the branch in this stage; it is held off during a stall or reset.
  always_comb begin
    br_taken = 1'b0;
    case (br_type)
      2'd1:    br_taken = (port1 == '0);
      2'd2:    br_taken = (port1 != port2);
      2'd3:    br_taken = 1'b1;
      default: br_taken = 1'b0;
    endcase
    if (hazard_stall || rst)
      br_taken = 1'b0;
  end

  assign br_addr = pc_in + {{14{instruction[15]}}, instruction[15:0], 2'b00};

  // Register file: reset clears every entry and discards a write in the same cycle; writes to R0 are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_N; i++)
        rf[i] <= '0;
    end else if (wb_en_in && (wb_dest != 5'd0)) begin
      rf[wb_dest] <= wb_value;
    end
  end

  // ID/EX boundary: reset, flush and stall all load an all-zero bubble; otherwise capture the decoded instruction.
  always_ff @(posedge clk) begin
    if (rst || flush || hazard_stall) begin
      ex_pc        <= '0;
      ex_val1      <= '0;
      ex_val2      <= '0;
      ex_st_val    <= '0;
      ex_dest      <= '0;
      ex_src1      <= '0;
      ex_src2      <= '0;
      ex_exe_cmd   <= '0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
      ex_wb_en     <= 1'b0;
    end else begin
      ex_pc        <= pc_in;
      ex_val1      <= port1;
      ex_val2      <= is_immediate ? simm : port2;
      ex_st_val    <= port2;
      ex_dest      <= dest_f;
      ex_src1      <= src1;
      ex_src2      <= src2;
      ex_exe_cmd   <= exe_cmd;
      ex_mem_read  <= mem_read;
      ex_mem_write <= mem_write;
      ex_wb_en     <= wb_en & ~mem_write;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: table of vectors plus short hand-written sequences.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst, hazard_stall, flush, wb_en_in;
  logic [31:0] instruction, pc_in, wb_value;
  logic [4:0]  wb_dest;
  logic [4:0]  src1, src2, ex_dest, ex_src1, ex_src2;
  logic        two_src, br_taken, ex_mem_read, ex_mem_write, ex_wb_en;
  logic [31:0] br_addr, ex_pc, ex_val1, ex_val2, ex_st_val;
  logic [3:0]  ex_exe_cmd;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  id_stage dut (
    .clk(clk), .rst(rst), .instruction(instruction), .pc_in(pc_in),
    .hazard_stall(hazard_stall), .flush(flush), .wb_en_in(wb_en_in),
    .wb_dest(wb_dest), .wb_value(wb_value), .src1(src1), .src2(src2),
    .two_src(two_src), .br_taken(br_taken), .br_addr(br_addr),
    .ex_pc(ex_pc), .ex_val1(ex_val1), .ex_val2(ex_val2), .ex_st_val(ex_st_val),
    .ex_dest(ex_dest), .ex_src1(ex_src1), .ex_src2(ex_src2),
    .ex_exe_cmd(ex_exe_cmd), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_wb_en(ex_wb_en)
  );

  typedef struct {
    logic        rst, stall, flush, wbe;
    logic [4:0]  wbd;
    logic [31:0] wbv, ins, pc;
    logic        e_br;
    logic [31:0] e_baddr;
    logic [4:0]  e_s2;
    logic        e_two;
    logic [31:0] e_pc, e_v1, e_v2, e_st;
    logic [4:0]  e_dest, e_es1, e_es2;
    logic [3:0]  e_exe;
    logic        e_mr, e_mw, e_wb;
  } vec_t;

  localparam int NV = 19;
  vec_t vec [NV];

  function automatic logic [31:0] enc(input int op, input int d, input int s1, input logic [15:0] imm);
    return {op[5:0], d[4:0], s1[4:0], imm};
  endfunction

  function automatic logic [15:0] rs2(input int s2);
    return {s2[4:0], 11'd0};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic st, input logic fl, input logic we,
                       input logic [4:0] wd, input logic [31:0] wv,
                       input logic [31:0] ins, input logic [31:0] pc);
    rst = r; hazard_stall = st; flush = fl; wb_en_in = we;
    wb_dest = wd; wb_value = wv; instruction = ins; pc_in = pc;
  endtask

  task automatic check_ex(input string tag, input vec_t v);
    check({tag, " ex_pc"},        ex_pc,               v.e_pc);
    check({tag, " ex_val1"},      ex_val1,             v.e_v1);
    check({tag, " ex_val2"},      ex_val2,             v.e_v2);
    check({tag, " ex_st_val"},    ex_st_val,           v.e_st);
    check({tag, " ex_dest"},      32'(ex_dest),        32'(v.e_dest));
    check({tag, " ex_src1"},      32'(ex_src1),        32'(v.e_es1));
    check({tag, " ex_src2"},      32'(ex_src2),        32'(v.e_es2));
    check({tag, " ex_exe_cmd"},   32'(ex_exe_cmd),     32'(v.e_exe));
    check({tag, " ex_mem_read"},  32'(ex_mem_read),    32'(v.e_mr));
    check({tag, " ex_mem_write"}, 32'(ex_mem_write),   32'(v.e_mw));
    check({tag, " ex_wb_en"},     32'(ex_wb_en),       32'(v.e_wb));
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0);

    //            rst st fl wbe wbd wbv           instruction                    pc        br baddr   s2  two  e_pc      v1        v2            st        dst es1 es2 exe mr mw wb
    vec[0]  = '{1,0,0,1, 3, 32'd5,      32'd0,                      32'h0,    0,32'h0,  0, 1, 32'h0,   32'd0,    32'd0,        32'd0,    0, 0, 0, 0, 0,0,0};
    vec[1]  = '{0,0,0,0, 0, 32'd0,      enc(1,1,3,16'd0),           32'h4,    0,32'h0,  0, 1, 32'h4,   32'd0,    32'd0,        32'd0,    1, 3, 0, 0, 0,0,1};
    vec[2]  = '{0,0,0,1, 4, 32'h1234,   enc(1,2,4,16'd0),           32'h8,    0,32'h0,  0, 1, 32'h8,   32'h1234, 32'd0,        32'd0,    2, 4, 0, 0, 0,0,1};
    vec[3]  = '{0,0,0,1, 0, 32'hFFFF,   enc(1,5,0,16'd0),           32'hC,    0,32'h0,  0, 1, 32'hC,   32'd0,    32'd0,        32'd0,    5, 0, 0, 0, 0,0,1};
    vec[4]  = '{0,0,0,1, 1, 32'd10,     32'd0,                      32'h10,   0,32'h0,  0, 1, 32'h10,  32'd0,    32'd0,        32'd0,    0, 0, 0, 0, 0,0,0};
    vec[5]  = '{0,0,0,1, 7, 32'h55,     enc(32,6,1,16'hFFFD),       32'h14,   0,32'h0, 31, 0, 32'h14,  32'd10,   32'hFFFFFFFD, 32'd0,    6, 1,31, 0, 0,0,1};
    vec[6]  = '{0,0,0,0, 0, 32'd0,      enc(37,7,1,16'd8),          32'h18,   0,32'h0,  7, 1, 32'h18,  32'd10,   32'd8,        32'h55,   7, 1, 7, 0, 0,1,0};
    vec[7]  = '{0,0,0,0, 0, 32'd0,      enc(41,7,1,16'd4),          32'h100,  1,32'h110,7, 1, 32'h100, 32'd10,   32'd4,        32'h55,   7, 1, 7, 0, 0,0,0};
    vec[8]  = '{0,0,0,0, 0, 32'd0,      enc(40,0,0,16'd4),          32'h100,  1,32'h110,0, 0, 32'h100, 32'd0,    32'd4,        32'd0,    0, 0, 0, 0, 0,0,0};
    vec[9]  = '{0,0,0,0, 0, 32'd0,      enc(40,0,1,16'd4),          32'h100,  0,32'h0,  0, 0, 32'h100, 32'd10,   32'd4,        32'd0,    0, 1, 0, 0, 0,0,0};
    vec[10] = '{0,0,0,0, 0, 32'd0,      enc(42,0,0,16'hFFFF),       32'h100,  1,32'hFC,31, 0, 32'h100, 32'd0,    32'hFFFFFFFF, 32'd0,    0, 0,31, 0, 0,0,0};
    vec[11] = '{0,1,0,0, 0, 32'd0,      enc(41,7,1,16'd4),          32'h100,  0,32'h0,  7, 1, 32'h0,   32'd0,    32'd0,        32'd0,    0, 0, 0, 0, 0,0,0};
    vec[12] = '{0,0,1,0, 0, 32'd0,      enc(1,2,4,16'd0),           32'h8,    0,32'h0,  0, 1, 32'h0,   32'd0,    32'd0,        32'd0,    0, 0, 0, 0, 0,0,0};
    vec[13] = '{0,0,0,1, 7, 32'h77,     enc(1,3,1,rs2(7)),          32'h20,   0,32'h0,  7, 1, 32'h20,  32'd10,   32'h77,       32'h77,   3, 1, 7, 0, 0,0,1};
    vec[14] = '{1,0,1,0, 0, 32'd0,      enc(1,2,4,16'd0),           32'h8,    0,32'h0,  0, 1, 32'h0,   32'd0,    32'd0,        32'd0,    0, 0, 0, 0, 0,0,0};
    vec[15] = '{0,0,0,0, 0, 32'd0,      enc(1,1,1,rs2(7)),          32'h24,   0,32'h0,  7, 1, 32'h24,  32'd0,    32'd0,        32'd0,    1, 1, 7, 0, 0,0,1};
    vec[16] = '{0,0,0,0, 0, 32'd0,      enc(36,8,4,16'd2),          32'h28,   0,32'h0,  0, 0, 32'h28,  32'd0,    32'd2,        32'd0,    8, 4, 0, 0, 1,0,1};
    vec[17] = '{0,0,0,0, 0, 32'd0,      enc(3,9,0,16'd0),           32'h2C,   0,32'h0,  0, 1, 32'h2C,  32'd0,    32'd0,        32'd0,    9, 0, 0, 2, 0,0,1};
    vec[18] = '{0,0,0,0, 0, 32'd0,      enc(41,0,0,16'd4),          32'h30,   0,32'h0,  0, 1, 32'h30,  32'd0,    32'd4,        32'd0,    0, 0, 0, 0, 0,0,0};

    for (int i = 0; i < NV; i++) begin
      string tag;
      tag = $sformatf("v%0d", i);
      @(negedge clk);
      drive(vec[i].rst, vec[i].stall, vec[i].flush, vec[i].wbe, vec[i].wbd, vec[i].wbv, vec[i].ins, vec[i].pc);
      #1;
      check({tag, " br_taken"}, 32'(br_taken), 32'(vec[i].e_br));
      if (vec[i].e_br)
        check({tag, " br_addr"}, br_addr, vec[i].e_baddr);
      check({tag, " src2"},    32'(src2),    32'(vec[i].e_s2));
      check({tag, " two_src"}, 32'(two_src), 32'(vec[i].e_two));
      @(posedge clk);
      #1;
      check_ex(tag, vec[i]);
    end

    // Register persistence: write R12, then read it back from the array a cycle later.
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 5'd12, 32'hABCD, 32'd0, 32'h40);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, enc(1,13,12,rs2(12)), 32'h44);
    @(posedge clk); #1;
    check("persist ex_val1", ex_val1, 32'hABCD);
    check("persist ex_val2", ex_val2, 32'hABCD);

    // Two stalled cycles hold a bubble, then the same ADDI is accepted once released.
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, enc(32,14,12,16'd1), 32'h48);
    @(posedge clk); #1;
    check("stall1 ex_wb_en", 32'(ex_wb_en), 32'd0);
    @(posedge clk); #1;
    check("stall2 ex_dest", 32'(ex_dest), 32'd0);
    @(negedge clk);
    hazard_stall = 1'b0;
    @(posedge clk); #1;
    check("release ex_wb_en", 32'(ex_wb_en), 32'd1);
    check("release ex_val1", ex_val1, 32'hABCD);
    check("release ex_val2", ex_val2, 32'd1);
    check("release ex_dest", 32'(ex_dest), 32'd14);

    // Unknown opcode decodes to no controls.
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, enc(63,15,12,16'd0), 32'h4C);
    #1;
    check("unknown br_taken", 32'(br_taken), 32'd0);
    @(posedge clk); #1;
    check("unknown ex_wb_en", 32'(ex_wb_en), 32'd0);
    check("unknown ex_exe_cmd", 32'(ex_exe_cmd), 32'd0);
    check("unknown ex_mem_read", 32'(ex_mem_read), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
